excess3_bcd_stream_converter: RTL and testbench

- Multi-digit, bidirectional code converter between packed Excess-3 and packed BCD words.
- Converts one digit per clock (digit-serial) behind valid/ready handshakes on both sides.
- Reports per-digit invalid-code flags and keeps a saturating error-word counter.
- Sits between the decimal front-end (Excess-3 encoded) and BCD arithmetic/display logic; reused wherever packed decimal words cross that boundary.

---
 rtl/excess3_bcd_stream_converter.sv | 149 ++++++++++++++
 tb/tb_excess3_bcd_stream_converter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/excess3_bcd_stream_converter.sv
// Digit-serial packed Excess-3 <-> BCD converter with valid/ready on both sides.
// Flags invalid codes per digit and counts delivered error words, saturating.
module excess3_bcd_stream_converter #(
  parameter int NUM_DIGITS = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic [NUM_DIGITS-1:0]   out_err_mask,
  output logic                    out_err,
  input  logic                    clr_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int W    = 4 * NUM_DIGITS;
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [IDXW-1:0]      LAST    = IDXW'(NUM_DIGITS - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDXW-1:0]       idx;
  logic                  mode_q;
  logic [W-1:0]          data_q;
  logic [W-1:0]          res_q;
  logic [NUM_DIGITS-1:0] mask_q;

  logic [3:0] code;
  logic [3:0] dig;
  logic       bad;
  logic       accept;
  logic       deliver;
  logic       last;

  // Returns {invalid, digit}; invalid codes map to 4'hF.
  function automatic logic [4:0] conv(
    input logic [3:0] c,
    input logic       m
  );
    logic       ok;
    logic [3:0] d;
    if (m) begin
      ok = (c <= 4'd9);
      d  = c + 4'd3;
    end else begin
      ok = (c >= 4'd3) && (c <= 4'd12);
      d  = c - 4'd3;
    end
    return ok ? {1'b0, d} : {1'b1, 4'hF};
  endfunction

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;
  assign last    = (idx == LAST);

  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDXW'(i)) begin
        code = data_q[i*4 +: 4];
      end
    end
  end

  assign {bad, dig} = conv(code, mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CONV;
      CONV: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready  = 1'b1;
      (state == DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      mode_q <= 1'b0;
      data_q <= '0;
      res_q  <= '0;
      mask_q <= '0;
    end else if (accept) begin
      idx    <= '0;
      mode_q <= in_mode;
      data_q <= in_data;
      res_q  <= '0;
      mask_q <= '0;
    end else if (state == CONV) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDXW'(i)) begin
          res_q[i*4 +: 4] <= dig;
          mask_q[i]       <= bad;
        end
      end
      idx <= last ? '0 : idx + 1'b1;
    end
  end

  // Clear wins over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (deliver && out_err && err_count != CNT_MAX) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign out_data     = res_q;
  assign out_err_mask = mask_q;
  assign out_err      = |mask_q;

endmodule

// File: tb/tb_excess3_bcd_stream_converter.sv
// Directed bench for excess3_bcd_stream_converter.
// Table of words plus hand sequences for backpressure, saturation, reset.
module tb_excess3_bcd_stream_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_err_mask;
  logic        out_err;
  logic        clr_err = 1'b0;
  logic [1:0]  err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mode;
    logic [15:0] din;
    logic [15:0] dout;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  excess3_bcd_stream_converter #(
    .NUM_DIGITS(4),
    .ERR_CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err_mask(out_err_mask),
    .out_err     (out_err),
    .clr_err     (clr_err),
    .err_count   (err_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a word, then scramble inputs; returns edges until out_valid.
  task automatic send(input logic m, input logic [15:0] d,
                      output int lat);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 32'(w < 20), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = ~m;
    in_data  = ~d;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic deliver(input logic clr);
    out_ready = 1'b1;
    clr_err   = clr;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    clr_err   = 1'b0;
  endtask

  initial begin
    int          lat;
    int          exp_cnt;
    logic [15:0] held;

    vecs[0] = '{1'b0, 16'hC863, 16'h9530, 4'b0000};
    vecs[1] = '{1'b1, 16'h9530, 16'hC863, 4'b0000};
    vecs[2] = '{1'b1, 16'h00A9, 16'h33FC, 4'b0010};
    vecs[3] = '{1'b0, 16'h2F53, 16'hFF20, 4'b1100};
    vecs[4] = '{1'b0, 16'h3333, 16'h0000, 4'b0000};
    vecs[5] = '{1'b0, 16'h0000, 16'hFFFF, 4'b1111};
    vecs[6] = '{1'b0, 16'hD0C1, 16'hFF9F, 4'b1101};
    vecs[7] = '{1'b1, 16'h0912, 16'h3C45, 4'b0000};
    vecs[8] = '{1'b1, 16'hBA98, 16'hFFCB, 4'b1100};
    vecs[9] = '{1'b0, 16'hC3C3, 16'h9090, 4'b0000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_mask", 32'(out_err_mask), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].mode, vecs[i].din, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].dout));
      chk($sformatf("v%0d_mask", i), 32'(out_err_mask),
          32'(vecs[i].mask));
      chk($sformatf("v%0d_err", i), 32'(out_err), 32'(|vecs[i].mask));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
      deliver(1'b0);
      if (|vecs[i].mask && exp_cnt < 3) exp_cnt++;
      chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(exp_cnt));
      chk($sformatf("v%0d_idle", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_valid_low", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: output held, new offers ignored.
    send(1'b0, 16'hC863, lat);
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h4444;
      in_mode  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_data", k), 32'(out_data), 32'(held));
    end
    chk("bp_data_value", 32'(held), 32'h9530);
    deliver(1'b0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Saturation with a 2-bit counter, then clear racing an increment.
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("sat_clr", 32'(err_count), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      send(1'b0, 16'h2F53, lat);
      deliver(1'b0);
      chk($sformatf("sat%0d", k), 32'(err_count), 32'((k < 3) ? k : 3));
    end
    send(1'b0, 16'h2F53, lat);
    chk("sat6_err", 32'(out_err), 32'd1);
    deliver(1'b1);
    chk("sat6_clr_priority", 32'(err_count), 32'd0);

    // Async reset mid-conversion at idx=2.
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = 1'b1;
    in_data  = 16'h0912;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_partial_data", 32'(out_data), 32'h0045);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_mask", 32'(out_err_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    send(1'b0, 16'h3333, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_data", 32'(out_data), 32'h0000);
    chk("post_rst_err", 32'(out_err), 32'd0);
    deliver(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
